// File: rtl/div_unit.sv
// div_unit: sequential signed-magnitude restoring divider, one quotient bit per cycle
module div_unit #(
  parameter int WHOLE_W = 7,
  parameter int PROD_W  = 15,
  parameter int OUT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PROD_W-1:0]  dividend,
  input  logic               signA,
  input  logic [WHOLE_W-1:0] divisor,
  input  logic               signB,
  output logic [OUT_W-1:0]   out,
  output logic [WHOLE_W-1:0] remainder,
  output logic               sign,
  output logic               overflow,
  output logic               divzero,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(PROD_W + 1);
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [PROD_W-1:0]   quo_q, quo_d, out_q;
  logic [WHOLE_W-1:0]  dvs_q, rem_out_q;
  logic [WHOLE_W:0]    rem_q, rem_d, rem_sh;
  logic [WHOLE_W+1:0]  diff;
  logic                sgn_q, sign_q, ovf_q, dz_q, busy_q, done_q, q_bit;
  assign out       = OUT_W'(out_q);
  assign remainder = rem_out_q;
  assign sign      = sign_q;
  assign overflow  = ovf_q;
  assign divzero   = dz_q;
  assign busy      = busy_q;
  assign done      = done_q;
  // one restoring step: shift in next dividend bit, subtract divisor when it fits
  always_comb begin
    rem_sh = {rem_q[WHOLE_W-1:0], quo_q[PROD_W-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
    q_bit  = ~diff[WHOLE_W+1];
    rem_d  = q_bit ? diff[WHOLE_W:0] : rem_sh;
    quo_d  = {quo_q[PROD_W-2:0], q_bit};
  end
  // control FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      sgn_q     <= 1'b0;
      out_q     <= '0;
      rem_out_q <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_DIV: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(PROD_W - 1)) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            out_q     <= quo_d;
            rem_out_q <= rem_d[WHOLE_W-1:0];
            sign_q    <= sgn_q & (|quo_d);
            ovf_q     <= quo_d > PROD_W'(2**WHOLE_W - 1);
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
          if (start) begin
            quo_q <= dividend;
            dvs_q <= divisor;
            sgn_q <= signA ^ signB;
            rem_q <= '0;
            cnt_q <= '0;
            ovf_q <= divisor == '0;
            dz_q  <= divisor == '0;
            if (divisor == '0) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              out_q     <= '1;
              rem_out_q <= '0;
              sign_q    <= signA ^ signB;
            end else begin
              state_q <= S_DIV;
              busy_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector bench for div_unit
module tb_div_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [14:0] dividend = '0;
  logic [6:0]  divisor = '0;
  logic        signA = 1'b0, signB = 1'b0;
  logic [31:0] out;
  logic [6:0]  remainder;
  logic        sign, overflow, divzero, busy, done;
  int n_vec = 0, n_err = 0, cyc = 0, t0 = 0, lat = 0, seen = 0;
  typedef struct {
    logic [14:0] dvd; logic sa; logic [6:0] dvs; logic sb;
    int q; int r; int s; int ov; int dz; int lt;
  } vec_t;
  vec_t v[10];
  div_unit dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .signA(signA),
    .divisor(divisor), .signB(signB), .out(out), .remainder(remainder), .sign(sign),
    .overflow(overflow), .divzero(divzero), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic go(input logic [14:0] a, input logic sa, input logic [6:0] b, input logic sb);
    dividend = a; signA = sa; divisor = b; signB = sb; start = 1'b1;
    @(posedge clk);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        l = cyc - t0;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic chk_res(input string nm, input vec_t e);
    wait_done(lat);
    chk({nm, " latency"}, lat, e.lt);
    chk({nm, " out"}, int'(out), e.q);
    chk({nm, " remainder"}, int'(remainder), e.r);
    chk({nm, " sign"}, int'(sign), e.s);
    chk({nm, " overflow"}, int'(overflow), e.ov);
    chk({nm, " divzero"}, int'(divzero), e.dz);
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " out"}, int'(out), 0);
    chk({nm, " remainder"}, int'(remainder), 0);
    chk({nm, " flags"}, int'({sign, overflow, divzero, busy, done}), 0);
  endtask
  initial begin
    v[0] = '{100,   0, 7,   1, 14,    2,  1, 0, 0, 16};
    v[1] = '{16129, 1, 127, 1, 127,   0,  0, 0, 0, 16};
    v[2] = '{1000,  0, 3,   0, 333,   1,  0, 1, 0, 16};
    v[3] = '{50,    1, 0,   0, 32767, 0,  1, 1, 1, 1};
    v[4] = '{0,     1, 5,   0, 0,     0,  0, 0, 0, 16};
    v[5] = '{32767, 0, 1,   0, 32767, 0,  0, 1, 0, 16};
    v[6] = '{5,     1, 127, 0, 0,     5,  0, 0, 0, 16};
    v[7] = '{128,   0, 1,   0, 128,   0,  0, 1, 0, 16};
    v[8] = '{127,   0, 1,   1, 127,   0,  1, 0, 0, 16};
    v[9] = '{32767, 1, 127, 0, 258,   1,  1, 1, 0, 16};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_zero("reset");
    foreach (v[k]) begin
      go(v[k].dvd, v[k].sa, v[k].dvs, v[k].sb);
      chk_res($sformatf("vec%0d", k), v[k]);
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", k), int'(done), 0);
    end
    go(100, 0, 7, 1);
    chk("busy in DIV", int'(busy), 1);
    repeat (4) @(negedge clk);
    dividend = 1000; divisor = 3; signB = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_res("busy start ignored", v[0]);
    chk("busy in DONE", int'(busy), 0);
    go(1000, 0, 3, 0);
    chk_res("back-to-back", v[2]);
    @(negedge clk);
    go(100, 0, 7, 1);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 16129; divisor = 127;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid-run reset");
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("done after abort", seen, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    go(0, 1, 5, 0);
    chk_res("start after reset", v[4]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WHOLE_W, default 7, meaning magnitude width of the divisor and of the non-overflow quotient range.
REQ-002 SHALL have parameter PROD_W, default 15, meaning magnitude width of the dividend (2*WHOLE_W+1).
REQ-003 SHALL have parameter OUT_W, default 32, meaning width of the zero-extended quotient output.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  request pulse; sampled only in IDLE or DONE.
REQ-007 SHALL have port dividend  in  PROD_W  dividend magnitude.
REQ-008 SHALL have port signA  in  1  dividend sign (1 = negative).
REQ-009 SHALL have port divisor  in  WHOLE_W  divisor magnitude.
REQ-010 SHALL have port signB  in  1  divisor sign.
REQ-011 SHALL have port out  out  OUT_W  quotient magnitude, zero-extended from PROD_W bits.
REQ-012 SHALL have port remainder  out  WHOLE_W  remainder magnitude.
REQ-013 SHALL have port sign  out  1  quotient sign.
REQ-014 SHALL have port overflow  out  1  quotient magnitude > 2^WHOLE_W-1.
REQ-015 SHALL have port divzero  out  1  divisor was zero.
REQ-016 SHALL have port busy  out  1  division in progress.
REQ-017 SHALL have port done  out  1  one-cycle result-valid pulse.

Function
REQ-018 SHALL implement FSM states IDLE, DIV, DONE.
REQ-019 SHALL, in IDLE or DONE with start=1, latch dividend, divisor, signA^signB, clear the partial remainder, and go to DIV; if divisor=0, SHALL go to DONE instead.
REQ-020 SHALL, in DIV, perform one restoring-division step per cycle, MSB first: shift the partial remainder (WHOLE_W+1 bits) left with the next dividend bit; subtract the divisor if the result is not negative; shift the quotient bit in.
REQ-021 SHALL stay in DIV for exactly PROD_W cycles, counted by an internal counter, then go to DONE.
REQ-022 SHALL assert done for exactly one cycle in DONE and then return to IDLE, unless start=1, per REQ-019.
REQ-023 SHALL make outputs valid when done=1; latency is PROD_W+1 cycles from start sampled to done (16 at defaults); divide-by-zero latency is 1 cycle.
REQ-024 SHALL assert busy=1 exactly while in DIV.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on divide-by-zero, set out to 2^PROD_W-1 and remainder=0; SHALL set divzero=1, overflow=1, and sign to the latched XOR.
REQ-027 SHALL force sign=0 when the quotient is zero, because negative zero is not produced.
REQ-028 SHALL set overflow=1 iff the quotient is greater than 2^WHOLE_W-1.
REQ-029 SHALL keep out, remainder, sign, overflow and divzero unchanged from DONE until the next accepted start.
REQ-030 SHALL clear divzero and overflow on the cycle a new start is accepted.

Reset
REQ-031 SHALL, when reset=1 at a clock edge, force state IDLE and set out, remainder, sign, overflow, divzero, busy, done and the counter to 0.
REQ-032 SHALL give reset priority over start, including reset mid-DIV: the operation is aborted and done is never asserted for it.
REQ-033 SHALL, on the first edge with reset=0 and start=1, accept the start normally.

Verification
REQ-034 SHALL cover: dividend=100, signA=0, divisor=7, signB=1 -> 16 cycles later done=1, out=14, remainder=2, sign=1, overflow=0.
REQ-035 SHALL cover: dividend=16129, divisor=127, both signs 1 -> out=127, remainder=0, sign=0, overflow=0.
REQ-036 SHALL cover: dividend=1000, divisor=3 -> out=333 (0x14D), remainder=1, overflow=1.
REQ-037 SHALL cover: divisor=0, dividend=50, signA=1 -> done on the next cycle, divzero=1, out=0x7FFF, remainder=0, overflow=1, sign=1.
REQ-038 SHALL cover: start, then reset at cycle 5, then start ignored mid-run -> after reset all outputs 0, busy=0, no done; a second start (dividend=0, divisor=5, signA=1) -> out=0, sign=0.
REQ-039 SHALL cover: start pulsed while busy=1 -> no effect; back-to-back start in the DONE cycle -> the new operation begins, with done 16 cycles later.
